fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Owns the architectural program counter and sequences instruction fetch for the CPU front end.
- Issues one request at a time to the instruction memory over a valid/ready handshake, then hands the fetched instruction and its PC to decode over a valid/ready handshake.
- Computes the sequential next PC (pc + 4) internally.
- Accepts branch/jump redirects from execute and discards any fetch that is in flight when a redirect arrives.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  32  redirect target.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  32  fetch address.
- imem_req_ready  in  1  imem accepts request.
- imem_rsp_valid  in  1  fetch data returned (single-cycle pulse per request).
- imem_rsp_data  in  32  instruction word.
- if_valid  out  1  instruction available to decode.
- if_pc  out  32  PC of delivered instruction.
- if_inst  out  32  delivered instruction.
- if_ready  in  1  decode accepts instruction.
- misalign_err  out  1  sticky: a redirect target had bits[1:0] != 0.
- fetch_count  out  32  number of instructions accepted by decode.

Behaviour:
- Reset (rstn low, asynchronous): pc = RESET_PC, state = IDLE.
  - imem_req_valid, if_valid, misalign_err = 0; if_pc, if_inst, fetch_count = 0.
  - Assertion anywhere, including mid-request, aborts all activity. A response arriving after reset is ignored until the next request is accepted.
- imem_req_addr = pc, combinationally. if_pc = the PC latched with the instruction.
- Redirect target handling: redirect_pc[1:0] is forced to 2'b00 before loading pc. If those bits were non-zero, misalign_err sets and holds until reset.
- Next-PC arithmetic: pc + 4, modulo 2^32. 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- IDLE: all outputs invalid; moves to REQ the cycle after reset deasserts. A redirect in IDLE loads pc.
- REQ: imem_req_valid = 1.
  - ready=1, no redirect -> WAIT.
  - ready=1 and redirect -> pc = target, -> DROP (the accepted request is orphaned).
  - ready=0 and redirect -> pc = target, stay REQ. This is the only case where addr may change while valid is held.
  - ready=0, no redirect -> hold addr stable.
- WAIT: imem_req_valid = 0.
  - rsp_valid, no redirect -> latch if_inst = rsp_data and if_pc = pc, -> OUT.
  - rsp_valid and redirect -> discard data, pc = target, -> REQ.
  - redirect, no rsp -> pc = target, -> DROP.
- DROP: wait for rsp_valid, discard the data, -> REQ. A further redirect in DROP overwrites pc and stays in DROP.
- OUT: if_valid = 1; if_pc and if_inst are held stable while if_ready = 0.
  - if_ready=1, no redirect -> pc = pc + 4, fetch_count + 1 (wraps), -> REQ.
  - redirect (priority over if_ready) -> pc = target, if_valid = 0 next cycle, no count, -> REQ.
- At most one outstanding imem request at any time.
- Best-case throughput: one instruction per 3 cycles (REQ, WAIT, OUT), with imem ready and responding one cycle after acceptance.
- Undefined-state recovery: any unused state encoding returns to IDLE.

Test Plan:
- Reset then free run, imem always ready with 1-cycle response, if_ready=1 -> if_pc = 0x0, 0x4, 0x8 on successive if_valid pulses 3 cycles apart; fetch_count = 3 after the third.
- Hold if_ready=0 for 5 cycles in OUT -> if_valid, if_pc, if_inst stable; no new imem_req_valid; pc advances only on the if_ready=1 cycle.
- Redirect to 0x100 during WAIT, response 2 cycles later -> response discarded (never appears on if_inst); next imem_req_addr = 0x100; if_pc = 0x100 delivered.
- Redirect to 0x203 while in REQ with imem_req_ready=0 -> imem_req_addr changes to 0x200 the next cycle; misalign_err = 1 and stays 1 through later fetches.
- Start at pc = 0xFFFF_FFFC (RESET_PC override), accept once -> next imem_req_addr = 0x0000_0000.
- Assert rstn low while in WAIT, release, then send a stale rsp_valid -> no if_valid; fetch restarts at RESET_PC; fetch_count = 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Front-end fetch sequencer: owns the PC, issues one imem request at a time,
// and hands instruction/PC pairs to decode; execute redirects flush in-flight fetches.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  input  logic        if_ready,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DROP,
    S_OUT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic [31:0] cnt_q, cnt_d;
  logic        mis_q, mis_d;
  logic        req_valid_q;
  logic        if_valid_q;
  logic [31:0] tgt;
  logic [31:0] pc_inc;

  assign tgt    = {redirect_pc[31:2], 2'b00};
  assign pc_inc = pc_q + 32'd4;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    if_pc_d   = if_pc_q;
    if_inst_d = if_inst_q;
    cnt_d     = cnt_q;
    mis_d     = mis_q | (redirect_valid & (|redirect_pc[1:0]));
    // A redirect always wins the PC, whatever the state
    if (redirect_valid) pc_d = tgt;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_req_ready)
          state_d = redirect_valid ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (redirect_valid) begin
            state_d = S_REQ;
          end else begin
            state_d   = S_OUT;
            if_inst_d = imem_rsp_data;
            if_pc_d   = pc_q;
          end
        end else if (redirect_valid) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_rsp_valid) state_d = S_REQ;
      end
      S_OUT: begin
        if (redirect_valid) begin
          state_d = S_REQ;
        end else if (if_ready) begin
          pc_d    = pc_inc;
          cnt_d   = cnt_q + 32'd1;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      if_pc_q     <= 32'd0;
      if_inst_q   <= 32'd0;
      cnt_q       <= 32'd0;
      mis_q       <= 1'b0;
      req_valid_q <= 1'b0;
      if_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      if_pc_q     <= if_pc_d;
      if_inst_q   <= if_inst_d;
      cnt_q       <= cnt_d;
      mis_q       <= mis_d;
      req_valid_q <= (state_d == S_REQ);
      if_valid_q  <= (state_d == S_OUT);
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign if_valid       = if_valid_q;
  assign if_pc          = if_pc_q;
  assign if_inst        = if_inst_q;
  assign misalign_err   = mis_q;
  assign fetch_count    = cnt_q;

endmodule
